intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/intr_ctrl.sv | 115 +++++++++++
 tb/tb_intr_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and
// the default sizing constants used by the controller and its arbiter.
package intr_pkg;

  // Default number of interrupt sources and serviced-event counter width.
  localparam int N_SRC_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Controller states: wait for work, offer to consumer, consumer servicing,
  // acknowledge the source.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at the index after
// ptr and wraps from N_SRC-1 to 0; the first requesting index wins.
module rr_arbiter
  import intr_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_idx
);

  // Walk candidates from farthest to nearest so the nearest requester after
  // ptr is the last one written and therefore wins.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before any conditional assignment so
    // no path leaves a value unassigned, which would otherwise infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_SRC;
      if (req[ID_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Round-robin interrupt controller. Picks one eligible level interrupt,
// offers it to a consumer with a valid/ready handshake, waits for the
// service-done pulse, then acknowledges the source for one cycle.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         intr,
  output logic [N_SRC-1:0]         intr_ack,
  input  logic [N_SRC-1:0]         mask,
  output logic                     irq_valid,
  output logic [$clog2(N_SRC)-1:0] irq_id,
  input  logic                     irq_ready,
  input  logic                     svc_done,
  output logic                     busy,
  output logic [CNT_W-1:0]         svc_cnt
);

  localparam int ID_W = $clog2(N_SRC);

  state_e              r_state;
  state_e              w_next_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_irq_id;
  logic [ID_W-1:0]     w_irq_id_nxt;
  logic                r_irq_valid;
  logic                r_busy;
  logic [N_SRC-1:0]    r_intr_ack;
  logic [N_SRC-1:0]    w_intr_ack_nxt;
  logic [CNT_W-1:0]    r_svc_cnt;
  logic [N_SRC-1:0]    w_req;
  logic                w_grant_valid;
  logic [ID_W-1:0]     w_grant_idx;

  assign w_req = intr & mask;

  rr_arbiter #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req         (w_req),
    .ptr         (r_ptr),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // Next-state and next-output decode; the selection is only taken in IDLE,
  // so mask/intr changes after that cannot alter the committed source.
  always_comb begin
    w_next_state   = r_state;
    w_irq_id_nxt   = r_irq_id;
    w_intr_ack_nxt = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_next_state = ST_REQ;
          w_irq_id_nxt = w_grant_idx;
        end
      end
      ST_REQ: begin
        if (irq_ready) w_next_state = ST_SVC;
      end
      ST_SVC: begin
        if (svc_done) w_next_state = ST_ACK;
      end
      ST_ACK: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (w_next_state == ST_ACK) w_intr_ack_nxt[r_irq_id] = 1'b1;
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Registered outputs, counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_id    <= '0;
      r_irq_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_intr_ack  <= '0;
      r_svc_cnt   <= '0;
      r_ptr       <= ID_W'(N_SRC - 1);
    end else begin
      r_irq_id    <= w_irq_id_nxt;
      r_irq_valid <= (w_next_state == ST_REQ);
      r_busy      <= (w_next_state != ST_IDLE);
      r_intr_ack  <= w_intr_ack_nxt;
      if (w_next_state == ST_ACK) r_svc_cnt <= r_svc_cnt + CNT_W'(1);
      // The pointer moves as ACK completes so the following IDLE search
      // starts just past the source that was served.
      if (r_state == ST_ACK) r_ptr <= r_irq_id;
    end
  end

  assign intr_ack  = r_intr_ack;
  assign irq_valid = r_irq_valid;
  assign irq_id    = r_irq_id;
  assign busy      = r_busy;
  assign svc_cnt   = r_svc_cnt;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: a driver issues directed and random
// transactions and pushes expected offers/acks predicted by a behavioural
// model; a monitor compares whatever the DUT presents against the queues.
module tb_intr_ctrl;

  localparam int N_SRC = 4;
  localparam int CNT_W = 2;
  localparam int ID_W  = $clog2(N_SRC);

  logic             clk;
  logic             rst_n;
  logic [N_SRC-1:0] intr;
  logic [N_SRC-1:0] intr_ack;
  logic [N_SRC-1:0] mask;
  logic             irq_valid;
  logic [ID_W-1:0]  irq_id;
  logic             irq_ready;
  logic             svc_done;
  logic             busy;
  logic [CNT_W-1:0] svc_cnt;

  typedef struct {
    logic [N_SRC-1:0] ack;
    logic [CNT_W-1:0] cnt;
  } ack_exp_t;

  int       exp_id_q[$];
  ack_exp_t exp_ack_q[$];

  int n_checks;
  int n_fail;
  int drv_err;
  bit drv_done;
  int model_last;
  int model_cnt;

  intr_ctrl #(
    .N_SRC (N_SRC),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .intr      (intr),
    .intr_ack  (intr_ack),
    .mask      (mask),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ready (irq_ready),
    .svc_done  (svc_done),
    .busy      (busy),
    .svc_cnt   (svc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rule: lowest eligible index above the last served one,
  // otherwise the lowest eligible index overall; -1 when nothing eligible.
  function automatic int rr_pick(input logic [N_SRC-1:0] elig, input int last);
    int lowest;
    int after;
    lowest = -1;
    after  = -1;
    for (int i = 0; i < N_SRC; i++) begin
      if (elig[i]) begin
        if (lowest < 0) lowest = i;
        if (i > last && after < 0) after = i;
      end
    end
    return (after >= 0) ? after : lowest;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // One full transaction, called at a negedge while the DUT will be in IDLE
  // at the next edge. rdy_delay < 0 means irq_ready is held high.
  task automatic service(input int rdy_delay, input int done_delay, input bit abuse,
                         input bit chg_mask, input logic [N_SRC-1:0] svc_mask);
    int               win;
    bit               got;
    logic [N_SRC-1:0] ack_seen;
    ack_exp_t         e;
    win = rr_pick(intr & mask, model_last);
    if (win < 0) begin
      drv_err++;
      return;
    end
    exp_id_q.push_back(win);
    irq_ready = (rdy_delay < 0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = irq_valid;
    end
    if (!got) begin
      drv_err++;
      return;
    end
    if (rdy_delay >= 0) begin
      repeat (rdy_delay) @(negedge clk);
      irq_ready = 1'b1;
      if (abuse) svc_done = 1'b1;
    end
    @(negedge clk);
    svc_done = 1'b0;
    if (rdy_delay >= 0) irq_ready = 1'b0;
    if (chg_mask) mask = svc_mask;
    repeat (done_delay) @(negedge clk);
    svc_done = 1'b1;
    e.ack = N_SRC'(1) << win;
    e.cnt = CNT_W'((model_cnt + 1) % (1 << CNT_W));
    exp_ack_q.push_back(e);
    @(negedge clk);
    svc_done   = 1'b0;
    model_cnt  = (model_cnt + 1) % (1 << CNT_W);
    model_last = win;
    ack_seen   = intr_ack;
    intr       = intr & ~ack_seen;
  endtask

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    int rd;
    drv_done   = 1'b0;
    drv_err    = 0;
    rst_n      = 1'b0;
    intr       = '0;
    mask       = '0;
    irq_ready  = 1'b0;
    svc_done   = 1'b0;
    model_last = N_SRC - 1;
    model_cnt  = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin over 1011, then source 0 raised again.
    mask = 4'b1111;
    intr = 4'b1011;
    repeat (3) service(-1, 1, 1'b0, 1'b0, '0);
    intr = intr | 4'b0001;
    service(-1, 2, 1'b0, 1'b0, '0);

    // Single source; fifth service wraps the 2-bit counter to 1.
    intr = 4'b0100;
    service(-1, 3, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);

    // Masking: only id 1 eligible; enabling bit 0 in SVC leaves id 1 committed.
    intr = 4'b0011;
    mask = 4'b0010;
    service(-1, 2, 1'b0, 1'b1, 4'b1111);
    service(-1, 1, 1'b0, 1'b0, '0);

    // Handshake abuse: svc_done in IDLE, then together with irq_ready in REQ.
    @(negedge clk);
    svc_done = 1'b1;
    @(negedge clk);
    svc_done = 1'b0;
    repeat (2) @(negedge clk);
    intr = 4'b0010;
    service(1, 2, 1'b1, 1'b0, '0);

    // Reset in SVC: no ack, source stays pending and is offered again.
    intr = 4'b0001;
    exp_id_q.push_back(rr_pick(intr & mask, model_last));
    irq_ready = 1'b1;
    rd = 0;
    while (!irq_valid && rd < 20) begin
      @(negedge clk);
      rd++;
    end
    if (rd >= 20) drv_err++;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_last = N_SRC - 1;
    model_cnt  = 0;
    rst_n = 1'b1;
    service(-1, 1, 1'b0, 1'b0, '0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      intr = intr | N_SRC'($urandom_range(0, (1 << N_SRC) - 1));
      mask = N_SRC'($urandom_range(0, (1 << N_SRC) - 1));
      if ((intr & mask) == '0) begin
        svc_done = 1'b1;
        @(negedge clk);
        svc_done = 1'b0;
        @(negedge clk);
      end else begin
        rd = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 2));
        service(rd, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'b1, N_SRC'($urandom_range(0, (1 << N_SRC) - 1)));
      end
    end
    repeat (3) @(negedge clk);
    drv_done = 1'b1;
  end

  // Monitor: samples 1 time unit after each rising edge and scores outputs.
  initial begin
    bit       prev_valid;
    bit       prev_ack;
    int       cur_id;
    int       eid;
    ack_exp_t ea;
    n_checks   = 0;
    n_fail     = 0;
    prev_valid = 1'b0;
    prev_ack   = 1'b0;
    cur_id     = 0;
    while (!drv_done) begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("rst_intr_ack", 32'(intr_ack), 32'd0);
        check("rst_irq_valid", 32'(irq_valid), 32'd0);
        check("rst_irq_id", 32'(irq_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_svc_cnt", 32'(svc_cnt), 32'd0);
        prev_valid = 1'b0;
        prev_ack   = 1'b0;
        cur_id     = 0;
      end else begin
        if (prev_ack) check("busy_after_ack", 32'(busy), 32'd0);
        if (irq_valid && !prev_valid) begin
          if (exp_id_q.size() == 0) begin
            check("unexpected_offer", 32'(irq_valid), 32'd0);
          end else begin
            eid = exp_id_q.pop_front();
            check("irq_id", 32'(irq_id), 32'(eid));
            cur_id = eid;
          end
        end
        if (busy) check("irq_id_held", 32'(irq_id), 32'(cur_id));
        if (irq_valid) check("busy_in_req", 32'(busy), 32'd1);
        if (intr_ack != '0) begin
          if (exp_ack_q.size() == 0) begin
            check("unexpected_ack", 32'(intr_ack), 32'd0);
          end else begin
            ea = exp_ack_q.pop_front();
            check("intr_ack", 32'(intr_ack), 32'(ea.ack));
            check("svc_cnt", 32'(svc_cnt), 32'(ea.cnt));
          end
        end
        prev_valid = irq_valid;
        prev_ack   = (intr_ack != '0);
      end
    end
    check("offers_pending", 32'(exp_id_q.size()), 32'd0);
    check("acks_pending", 32'(exp_ack_q.size()), 32'd0);
    check("driver_timeouts", 32'(drv_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
